// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for the multicycle ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_EQ   = 4'b1010;
   localparam logic [3:0] OP_GT   = 4'b1011;
   localparam logic [3:0] OP_LT   = 4'b1100;
   localparam logic [3:0] OP_SHR1 = 4'b1101;
   localparam logic [3:0] OP_SHL1 = 4'b1110;
   localparam logic [3:0] OP_MOD  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   function automatic logic is_divmod(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider: one quotient bit per clock, OPERAND_WIDTH iterations total.
// The first iteration runs on the start edge itself, so done pulses OPERAND_WIDTH-1 edges later.
module alu_divider
   import alu_pkg::*;
#(
   parameter int OPERAND_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [OPERAND_WIDTH-1:0] dividend,
   input  logic [OPERAND_WIDTH-1:0] divisor,
   output logic                     busy,
   output logic                     done,
   output logic [OPERAND_WIDTH-1:0] quotient,
   output logic [OPERAND_WIDTH-1:0] remainder
);

   localparam int W  = OPERAND_WIDTH;
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [W-1:0]  step_rem;
   logic [W-1:0]  step_quot;
   logic [W-1:0]  step_dvs;
   logic [W:0]    partial;
   logic [W:0]    trial;
   logic [W:0]    quot_shift;
   logic [W-1:0]  rem_next;
   logic [W-1:0]  quot_next;

   // quot holds the not-yet-consumed dividend bits at the top and collects quotient bits at the bottom
   always_comb begin
      step_rem   = start ? '0       : rem_q;
      step_quot  = start ? dividend : quot_q;
      step_dvs   = start ? divisor  : dvs_q;
      partial    = {step_rem, step_quot[W-1]};
      trial      = partial - {1'b0, step_dvs};
      rem_next   = trial[W] ? partial[W-1:0] : trial[W-1:0];
      quot_shift = {step_quot, ~trial[W]};
      quot_next  = quot_shift[W-1:0];
   end

   always_comb begin
      rem_d  = rem_q;
      quot_d = quot_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start) begin
         rem_d  = rem_next;
         quot_d = quot_next;
         dvs_d  = divisor;
         cnt_d  = CW'(1);
         busy_d = (W > 1);
         done_d = (W == 1);
      end else if (busy_q) begin
         rem_d  = rem_next;
         quot_d = quot_next;
         cnt_d  = cnt_q + CW'(1);
         if (cnt_q == CW'(W - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quot_q <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops complete on the accept edge, div/mod run through alu_divider.
// Results and flags are registered and held in DONE until the consumer takes them.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int OPERAND_WIDTH = 8,
   parameter int OUTPUT_WIDTH  = 2 * OPERAND_WIDTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [OPERAND_WIDTH-1:0] A,
   input  logic [OPERAND_WIDTH-1:0] B,
   input  logic [3:0]               ALU_FUN,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   output logic [OUTPUT_WIDTH-1:0]  ALU_OUT,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic                     ZERO_FLAG,
   output logic                     DIV_ERR
);

   alu_state_t              state_q, state_d;
   logic [OUTPUT_WIDTH-1:0] alu_out_q, alu_out_d;
   logic                    zero_q, zero_d;
   logic                    div_err_q, div_err_d;
   logic                    out_valid_q, out_valid_d;
   logic                    mod_op_q, mod_op_d;

   logic [OUTPUT_WIDTH-1:0]  a_ext;
   logic [OUTPUT_WIDTH-1:0]  b_ext;
   logic [OUTPUT_WIDTH-1:0]  single_res;
   logic [OUTPUT_WIDTH-1:0]  div_res;
   logic                     b_zero;
   logic                     accept;
   logic                     div_start;
   logic                     div_busy;
   logic                     div_done;
   logic [OPERAND_WIDTH-1:0] div_quot;
   logic [OPERAND_WIDTH-1:0] div_rem;

   assign a_ext  = OUTPUT_WIDTH'(A);
   assign b_ext  = OUTPUT_WIDTH'(B);
   assign b_zero = (B == '0);

   // div_busy is only ever high in DIV; it guards against accepting while the divider is occupied
   assign IN_READY = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && OUT_READY)) && !div_busy;
   assign accept   = IN_VALID && IN_READY;

   // Div/mod entries here are the divide-by-zero results; a non-zero divisor goes to the divider
   always_comb begin
      single_res = '0;
      case (ALU_FUN)
         OP_ADD:  single_res = a_ext + b_ext;
         OP_SUB:  single_res = a_ext - b_ext;
         OP_MUL:  single_res = a_ext * b_ext;
         OP_DIV:  single_res = OUTPUT_WIDTH'({OPERAND_WIDTH{1'b1}});
         OP_AND:  single_res = a_ext & b_ext;
         OP_OR:   single_res = a_ext | b_ext;
         OP_NAND: single_res = ~(a_ext & b_ext);
         OP_NOR:  single_res = ~(a_ext | b_ext);
         OP_XOR:  single_res = a_ext ^ b_ext;
         OP_XNOR: single_res = ~(a_ext ^ b_ext);
         OP_EQ:   single_res = (a_ext == b_ext) ? OUTPUT_WIDTH'(1) : '0;
         OP_GT:   single_res = (a_ext >  b_ext) ? OUTPUT_WIDTH'(2) : '0;
         OP_LT:   single_res = (a_ext <  b_ext) ? OUTPUT_WIDTH'(3) : '0;
         OP_SHR1: single_res = a_ext >> 1;
         OP_SHL1: single_res = a_ext << 1;
         OP_MOD:  single_res = a_ext;
         default: single_res = '0;
      endcase
   end

   assign div_res = mod_op_q ? OUTPUT_WIDTH'(div_rem) : OUTPUT_WIDTH'(div_quot);

   always_comb begin
      state_d     = state_q;
      alu_out_d   = alu_out_q;
      zero_d      = zero_q;
      div_err_d   = div_err_q;
      out_valid_d = out_valid_q;
      mod_op_d    = mod_op_q;
      div_start   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               if (is_divmod(ALU_FUN) && !b_zero) begin
                  state_d     = ST_DIV;
                  out_valid_d = 1'b0;
                  mod_op_d    = (ALU_FUN == OP_MOD);
                  div_start   = 1'b1;
               end else begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b1;
                  alu_out_d   = single_res;
                  zero_d      = (single_res == '0);
                  div_err_d   = is_divmod(ALU_FUN);
               end
            end else if ((state_q == ST_DONE) && OUT_READY) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         ST_DIV: begin
            if (div_done) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               alu_out_d   = div_res;
               zero_d      = (div_res == '0);
               div_err_d   = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         alu_out_q   <= '0;
         zero_q      <= 1'b0;
         div_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         mod_op_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_out_q   <= alu_out_d;
         zero_q      <= zero_d;
         div_err_q   <= div_err_d;
         out_valid_q <= out_valid_d;
         mod_op_q    <= mod_op_d;
      end
   end

   alu_divider #(
      .OPERAND_WIDTH(OPERAND_WIDTH)
   ) u_divider (
      .clk       (CLK),
      .rst_n     (RST),
      .start     (div_start),
      .dividend  (A),
      .divisor   (B),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quot),
      .remainder (div_rem)
   );

   assign ALU_OUT   = alu_out_q;
   assign OUT_VALID = out_valid_q;
   assign ZERO_FLAG = zero_q;
   assign DIV_ERR   = div_err_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- OPERAND_WIDTH, 8, width of A and B.
- OUTPUT_WIDTH, 2*OPERAND_WIDTH, width of ALU_OUT.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, the single clock; all logic on its rising edge.
- RST, in, 1, asynchronous active-low reset.
- A, in, OPERAND_WIDTH, operand A.
- B, in, OPERAND_WIDTH, operand B.
- ALU_FUN, in, 4, opcode.
- IN_VALID, in, 1, request present.
- IN_READY, out, 1, request accepted this cycle when high with IN_VALID.
- ALU_OUT, out, OUTPUT_WIDTH, registered result.
- OUT_VALID, out, 1, ALU_OUT and flags valid.
- OUT_READY, in, 1, consumer accepts the result.
- ZERO_FLAG, out, 1, ALU_OUT equals 0.
- DIV_ERR, out, 1, divide or modulo by zero.

Function
REQ-003 Opcodes SHALL be: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 nand, 0111 nor, 1000 xor, 1001 xnor, 1010 eq, 1011 gt, 1100 lt, 1101 shr1, 1110 shl1, 1111 mod.
REQ-004 Operands SHALL be zero-extended to OUTPUT_WIDTH before every operation; add/sub/mul results SHALL be taken mod 2^OUTPUT_WIDTH (e.g. 3-5 = all ones minus 1).
REQ-005 Compare ops SHALL return: eq -> 1 if A==B else 0; gt -> 2 if A>B else 0; lt -> 3 if A<B else 0 (unsigned).
REQ-006 The FSM SHALL have states IDLE, DIV, DONE.
REQ-007 IN_READY SHALL equal (state==IDLE) OR (state==DONE AND OUT_READY).
REQ-008 A transfer SHALL occur only when IN_VALID and IN_READY are both high; A, B and ALU_FUN SHALL be captured at that edge.
REQ-009 A single-cycle op (not div/mod) SHALL go to DONE with OUT_VALID=1 on the edge after acceptance (latency 1).
REQ-010 Div/mod with B!=0 SHALL enter DIV and run a restoring divide of exactly OPERAND_WIDTH iterations, then go to DONE (latency OPERAND_WIDTH+1).
REQ-011 Div SHALL output the zero-extended quotient; mod SHALL output the zero-extended remainder.
REQ-012 Div/mod with B==0 SHALL skip DIV and go to DONE with latency 1, with DIV_ERR=1; div SHALL output the quotient as all ones in the low OPERAND_WIDTH bits, and mod SHALL output A.
REQ-013 In DONE, ALU_OUT, ZERO_FLAG, DIV_ERR and OUT_VALID SHALL hold stable until OUT_READY=1.
REQ-014 In DONE with OUT_READY=1 and a new transfer, the FSM SHALL go directly to the next op (back-to-back, throughput 1 for single-cycle ops).
REQ-015 In DONE with OUT_READY=1 and no transfer, the FSM SHALL go to IDLE with OUT_VALID=0.
REQ-016 In DIV, IN_READY SHALL be 0 and input changes SHALL be ignored.
REQ-017 ZERO_FLAG and DIV_ERR SHALL be registered with ALU_OUT; DIV_ERR SHALL be 0 for all non-div/mod ops.

Reset
REQ-018 While RST=0 the block SHALL asynchronously force state=IDLE, ALU_OUT=0, OUT_VALID=0, ZERO_FLAG=0, DIV_ERR=0, and clear all divider registers.
REQ-019 A reset during DIV or DONE SHALL discard the operation in progress; no OUT_VALID SHALL follow from it.
REQ-020 IN_READY SHALL be 1 on the first edge after reset release.

Structure
REQ-021 Package alu_pkg SHALL hold the 16 opcode constants and the FSM state typedef.
REQ-022 The divider SHALL be a sub-module, alu_divider, with start/busy/done, quotient and remainder, parameterised by OPERAND_WIDTH.

Verification
REQ-023 The bench SHALL cover these directed scenarios (OPERAND_WIDTH=8):
- Add 200+100 -> OUT_VALID next cycle, ALU_OUT=300, ZERO_FLAG=0.
- Sub 3-5 -> ALU_OUT=0xFFFE; xor 0x5A^0x5A -> ALU_OUT=0, ZERO_FLAG=1.
- Div 200/7 -> OUT_VALID exactly 9 cycles after acceptance, ALU_OUT=28; mod 200%7 -> ALU_OUT=4; IN_READY=0 throughout DIV.
- Div 50/0 -> latency 1, DIV_ERR=1, ALU_OUT=0x00FF; mod 50%0 -> ALU_OUT=50, DIV_ERR=1.
- OUT_READY held 0 for 5 cycles after an add -> ALU_OUT and OUT_VALID stable and IN_READY=0; then OUT_READY=1 with IN_VALID=1 for an or -> new result the next cycle.
- RST asserted mid-DIV -> all outputs 0 at once; after release no stale OUT_VALID, and a new mul 15*17 -> ALU_OUT=255.
